// File: rtl/maxnet_input_sequencer.sv
// maxnet_input_sequencer: loads four samples from a valid/ready stream,
// runs the max-finder network with a Done timeout, and returns the captured
// max, an abort flag and the run latency on a valid/ready result port.
module maxnet_input_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNTW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             nn_rst,
    output logic [WIDTH-1:0] nn_inp1,
    output logic [WIDTH-1:0] nn_inp2,
    output logic [WIDTH-1:0] nn_inp3,
    output logic [WIDTH-1:0] nn_inp4,
    input  logic             nn_done,
    input  logic [WIDTH-1:0] nn_max,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [CNTW-1:0]  lat_cycles,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX   = '1;
    localparam logic [CNTW-1:0] TIMEOUT_C = CNTW'(TIMEOUT);

    state_t            state_q,    state_d;
    logic [1:0]        cnt_q,      cnt_d;
    logic [WIDTH-1:0]  inp1_q,     inp1_d;
    logic [WIDTH-1:0]  inp2_q,     inp2_d;
    logic [WIDTH-1:0]  inp3_q,     inp3_d;
    logic [WIDTH-1:0]  inp4_q,     inp4_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;
    logic              res_err_q,  res_err_d;
    logic [CNTW-1:0]   lat_q,      lat_d;
    logic [CNTW-1:0]   run_cnt_q,  run_cnt_d;
    logic [CNTW-1:0]   run_cnt_inc;

    // Next-state and datapath decisions for LOAD / RUN / HOLD.
    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        inp1_d     = inp1_q;
        inp2_d     = inp2_q;
        inp3_d     = inp3_q;
        inp4_d     = inp4_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        lat_d      = lat_q;
        run_cnt_d  = run_cnt_q;
        run_cnt_inc = (run_cnt_q == CNT_MAX) ? run_cnt_q : run_cnt_q + CNTW'(1);

        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    unique case (cnt_q)
                        2'd0: inp1_d = in_data;
                        2'd1: inp2_d = in_data;
                        2'd2: inp3_d = in_data;
                        2'd3: inp4_d = in_data;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d   = S_RUN;
                        run_cnt_d = '0;
                    end
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_inc;
                // A counter of zero marks the first RUN cycle, where Done may be stale.
                if (nn_done && (run_cnt_q != '0)) begin
                    res_data_d = nn_max;
                    res_err_d  = 1'b0;
                    lat_d      = run_cnt_inc;
                    state_d    = S_HOLD;
                end else if (run_cnt_inc >= TIMEOUT_C) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    lat_d      = TIMEOUT_C;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            inp1_q     <= '0;
            inp2_q     <= '0;
            inp3_q     <= '0;
            inp4_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            lat_q      <= '0;
            run_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inp1_q     <= inp1_d;
            inp2_q     <= inp2_d;
            inp3_q     <= inp3_d;
            inp4_q     <= inp4_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            lat_q      <= lat_d;
            run_cnt_q  <= run_cnt_d;
        end
    end

    // Handshake and network-reset outputs are pure decodes of the registered state.
    assign in_ready   = (state_q == S_LOAD);
    assign nn_rst     = (state_q == S_LOAD);
    assign res_valid  = (state_q == S_HOLD);

    assign nn_inp1    = inp1_q;
    assign nn_inp2    = inp2_q;
    assign nn_inp3    = inp3_q;
    assign nn_inp4    = inp4_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign lat_cycles = lat_q;

endmodule
